// File: rtl/tx_arbiter.sv
// Round-robin transmit scheduler for a shared serial transmitter.
// One character per grant, with an idle gap and a SEND watchdog.
module tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 200
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       dataIn,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       timeoutErr,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grantId,
    output logic                       transmitEnable,
    output logic                       load,
    output logic [7:0]                 parallelDataOut,
    input  logic                       characterSent
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        DONE,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 ok_q, ok_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [IDW-1:0]       gid_q, gid_d;
    logic [7:0]           pdo_q, pdo_d;
    logic                 te_q, te_d;
    logic                 load_q, load_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;

    logic [IDW-1:0]       pick;
    logic                 found;
    int                   idx;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    // Next-state logic, grant latching and watchdog/gap counters
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        ok_d    = ok_q;
        last_d  = last_q;
        gid_d   = gid_q;
        pdo_d   = pdo_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOAD;
                    gid_d   = pick;
                    last_d  = pick;
                    pdo_d   = dataIn[8*int'(pick) +: 8];
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                cnt_d = cnt_q + 1'b1;
                if (characterSent) begin
                    ok_d    = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    ok_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs follow the state one cycle later (registered)
    always_comb begin
        te_d   = (state_q == LOAD) || (state_q == SEND);
        load_d = (state_q == LOAD) || (state_q == SEND);
        busy_d = (state_q != IDLE);
        ack_d  = '0;
        err_d  = 1'b0;
        if (state_q == DONE) begin
            if (ok_q) begin
                ack_d[gid_q] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            ok_q    <= 1'b0;
            last_q  <= IDW'(NUM_REQ - 1);
            gid_q   <= '0;
            pdo_q   <= '0;
            te_q    <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ok_q    <= ok_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            pdo_q   <= pdo_d;
            te_q    <= te_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign ack             = ack_q;
    assign timeoutErr      = err_q;
    assign busy            = busy_q;
    assign grantId         = gid_q;
    assign transmitEnable  = te_q;
    assign load            = load_q;
    assign parallelDataOut = pdo_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: grant timing, round robin,
// watchdog, coincident end, mid-frame changes, async reset.
module tb_tx_arbiter;

    localparam int N  = 4;
    localparam int G  = 2;
    localparam int TO = 200;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] dataIn;
    logic [N-1:0]   ack;
    logic           timeoutErr;
    logic           busy;
    logic [1:0]     grantId;
    logic           te;
    logic           load;
    logic [7:0]     pdo;
    logic           cs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tx_arbiter #(
        .NUM_REQ   (N),
        .GAP_CYCLES(G),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .dataIn         (dataIn),
        .ack            (ack),
        .timeoutErr     (timeoutErr),
        .busy           (busy),
        .grantId        (grantId),
        .transmitEnable (te),
        .load           (load),
        .parallelDataOut(pdo),
        .characterSent  (cs)
    );

    task automatic wait_te(input int bound, output int waited,
                           output bit ok);
        waited = 0;
        ok     = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            waited++;
            if (te) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        cs    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        req    = '0;
        cs     = 1'b0;
        dataIn = '0;
        #2 reset = 1'b0;
        #1;
        tests++;
        if (ack !== 4'b0000 || timeoutErr !== 1'b0) begin
            fails++;
            $display("FAIL reset_pulses: ack=%b err=%b need 0000/0",
                     ack, timeoutErr);
        end
        tests++;
        if (busy !== 1'b0 || te !== 1'b0 || load !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%b te=%b load=%b need 0",
                     busy, te, load);
        end
        tests++;
        if (grantId !== 2'd0 || pdo !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: gid=%0d pdo=%h need 0/00",
                     grantId, pdo);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int  waited;
        bit  ok;
        int  te_cnt;
        int  ack_cnt;
        int  to_cnt;
        logic [N-1:0] ack_val;
        te_cnt  = 0;
        ack_cnt = 0;
        to_cnt  = 0;
        ack_val = '0;
        dataIn  = 32'h0055_0000;
        req     = 4'b0100;
        wait_te(10, waited, ok);
        tests++;
        if (!ok || waited != 2) begin
            fails++;
            $display("FAIL single_latency: ok=%0d waited=%0d need 1/2",
                     ok, waited);
        end
        tests++;
        if (grantId !== 2'd2 || pdo !== 8'h55 || load !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: gid=%0d pdo=%h load=%b need 2/55/1",
                     grantId, pdo, load);
        end
        for (int i = 0; i < 400; i++) begin
            if (te) te_cnt++;
            if (timeoutErr) to_cnt++;
            if (ack != '0) begin
                ack_cnt++;
                ack_val = ack;
                req = req & ~ack;
            end
            cs = (i == 175);
            @(negedge clk);
        end
        tests++;
        if (te_cnt != 177) begin
            fails++;
            $display("FAIL single_te_len: got %0d need 177", te_cnt);
        end
        tests++;
        if (ack_cnt != 1 || ack_val !== 4'b0100 || to_cnt != 0) begin
            fails++;
            $display("FAIL single_ack: cnt=%0d val=%b err=%0d need 1/0100/0",
                     ack_cnt, ack_val, to_cnt);
        end
        tests++;
        if (busy !== 1'b0 || te !== 1'b0 || pdo !== 8'h55) begin
            fails++;
            $display("FAIL single_idle: busy=%b te=%b pdo=%h need 0/0/55",
                     busy, te, pdo);
        end
    endtask

    task automatic test_round_robin();
        int   waited;
        bit   ok;
        logic [N-1:0] exp_ack;
        logic [7:0]   exp_pdo;
        do_reset();
        dataIn = 32'hA3A2_A1A0;
        req    = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            exp_ack = 4'(1 << (f % 4));
            exp_pdo = 8'hA0 + 8'(f % 4);
            wait_te(20, waited, ok);
            tests++;
            if (!ok || grantId !== 2'(f % 4) || pdo !== exp_pdo) begin
                fails++;
                $display("FAIL rr_grant%0d: ok=%0d gid=%0d pdo=%h need %0d/%h",
                         f, ok, grantId, pdo, f % 4, exp_pdo);
            end
            if (f > 0) begin
                tests++;
                if (waited != G + 2) begin
                    fails++;
                    $display("FAIL rr_gap%0d: te low %0d cycles need %0d",
                             f, waited, G + 2);
                end
            end
            repeat (10) @(negedge clk);
            cs = 1'b1;
            @(negedge clk);
            cs = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (ack != '0) break;
            end
            tests++;
            if (ack !== exp_ack || timeoutErr !== 1'b0) begin
                fails++;
                $display("FAIL rr_ack%0d: ack=%b err=%b need %b/0",
                         f, ack, timeoutErr, exp_ack);
            end
        end
    endtask

    task automatic test_timeout();
        int waited;
        bit ok;
        int to_cnt;
        int to_idx;
        int rise_idx;
        int ack_cnt;
        to_cnt   = 0;
        to_idx   = -1;
        rise_idx = -1;
        ack_cnt  = 0;
        do_reset();
        dataIn = 32'h0000_003C;
        req    = 4'b0001;
        wait_te(10, waited, ok);
        for (int i = 0; i < 220; i++) begin
            if (timeoutErr) begin
                to_cnt++;
                if (to_idx < 0) to_idx = i;
            end
            if (ack != '0) ack_cnt++;
            if (to_idx >= 0 && te && rise_idx < 0) rise_idx = i;
            @(negedge clk);
        end
        tests++;
        if (!ok || to_cnt != 1 || to_idx != TO + 1) begin
            fails++;
            $display("FAIL to_pulse: ok=%0d cnt=%0d idx=%0d need 1/1/%0d",
                     ok, to_cnt, to_idx, TO + 1);
        end
        tests++;
        if (ack_cnt != 0) begin
            fails++;
            $display("FAIL to_noack: got %0d acks need 0", ack_cnt);
        end
        tests++;
        if (rise_idx != TO + 5 || grantId !== 2'd0 || pdo !== 8'h3C) begin
            fails++;
            $display("FAIL to_regrant: idx=%0d gid=%0d pdo=%h need %0d/0/3c",
                     rise_idx, grantId, pdo, TO + 5);
        end
    endtask

    task automatic test_coincident();
        int waited;
        bit ok;
        int ack_cnt;
        int ack_idx;
        int to_cnt;
        ack_cnt = 0;
        ack_idx = -1;
        to_cnt  = 0;
        do_reset();
        dataIn = 32'h0000_009A;
        req    = 4'b0001;
        wait_te(10, waited, ok);
        for (int i = 0; i < 220; i++) begin
            if (timeoutErr) to_cnt++;
            if (ack != '0) begin
                ack_cnt++;
                if (ack_idx < 0) ack_idx = i;
                req = req & ~ack;
            end
            cs = (i == TO - 1);
            @(negedge clk);
        end
        tests++;
        if (!ok || ack_cnt != 1 || ack_idx != TO + 1 || to_cnt != 0) begin
            fails++;
            $display("FAIL coincident: acks=%0d idx=%0d errs=%0d need 1/%0d/0",
                     ack_cnt, ack_idx, to_cnt, TO + 1);
        end
    endtask

    task automatic test_midframe();
        int   waited;
        bit   ok;
        int   ack_cnt;
        logic [N-1:0] ack_val;
        ack_cnt = 0;
        ack_val = '0;
        do_reset();
        dataIn = 32'h0000_7700;
        req    = 4'b0010;
        wait_te(10, waited, ok);
        for (int i = 0; i < 60; i++) begin
            if (i == 5) begin
                dataIn = 32'hFFFF_FFFF;
                req    = 4'b0000;
            end
            if (i == 20) begin
                tests++;
                if (pdo !== 8'h77 || te !== 1'b1) begin
                    fails++;
                    $display("FAIL mid_hold: pdo=%h te=%b need 77/1",
                             pdo, te);
                end
            end
            if (ack != '0) begin
                ack_cnt++;
                ack_val = ack;
            end
            cs = (i == 30);
            @(negedge clk);
        end
        tests++;
        if (!ok || ack_cnt != 1 || ack_val !== 4'b0010) begin
            fails++;
            $display("FAIL mid_ack: ok=%0d cnt=%0d val=%b need 1/1/0010",
                     ok, ack_cnt, ack_val);
        end
        tests++;
        if (pdo !== 8'h77 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_end: pdo=%h busy=%b need 77/0", pdo, busy);
        end
    endtask

    task automatic test_async_reset();
        int waited;
        bit ok;
        do_reset();
        dataIn = 32'h0044_1100;
        req    = 4'b0100;
        wait_te(10, waited, ok);
        repeat (50) @(negedge clk);
        tests++;
        if (!ok || te !== 1'b1 || grantId !== 2'd2) begin
            fails++;
            $display("FAIL ar_pre: ok=%0d te=%b gid=%0d need 1/1/2",
                     ok, te, grantId);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (te !== 1'b0 || load !== 1'b0 || busy !== 1'b0 || ack !== '0) begin
            fails++;
            $display("FAIL ar_drop: te=%b load=%b busy=%b ack=%b need 0",
                     te, load, busy, ack);
        end
        req = 4'b1010;
        @(negedge clk);
        reset = 1'b1;
        wait_te(10, waited, ok);
        tests++;
        if (!ok || waited != 2 || grantId !== 2'd1 || pdo !== 8'h11) begin
            fails++;
            $display("FAIL ar_restart: ok=%0d wait=%0d gid=%0d pdo=%h need 1/2/1/11",
                     ok, waited, grantId, pdo);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_coincident();
        test_midframe();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
